imm_sel_ctrl: RTL and testbench

Decode-side controller that sequences immediate expansion for the 32-bit RISC-V core. It accepts fetched instructions over a valid/ready handshake and classifies the opcode into the 3-bit immediate-type select used by the immediate generator. It produces the expanded 32-bit immediate and registers it, with a 2-entry skid buffer so back-pressure from execute never drops an instruction. It sits between fetch and the register-read/execute stage.

---
 rtl/imm_sel_ctrl_if.sv | 48 ++++
 rtl/imm_sel_ctrl.sv | 160 ++++++++++++++++
 tb/tb_imm_sel_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/imm_sel_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_sel_ctrl_if
// Description : Bundles the fetch-side and execute-side handshake and data
//               signals of imm_sel_ctrl.
//               slave  : the controller side (sees fetch inputs, drives results)
//               master : the environment side (drives fetch, consumes results)
//   flush        branch redirect, drops buffered entries
//   in_valid     fetch presents an instruction
//   in_ready     controller can accept this cycle
//   in_inst      instruction word
//   in_pc        instruction address
//   out_valid    registered result valid
//   out_ready    downstream accepts
//   out_inst     instruction passed through
//   out_pc       pc passed through
//   out_imm_sel  immediate type select
//   out_imm      expanded immediate
//   out_illegal  opcode has no immediate or is unrecognised
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_sel_ctrl_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_inst;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_inst;
   logic [XLEN-1:0] out_pc;
   logic [2:0]      out_imm_sel;
   logic [XLEN-1:0] out_imm;
   logic            out_illegal;

   modport slave (
      input  flush, in_valid, in_inst, in_pc, out_ready,
      output in_ready, out_valid, out_inst, out_pc, out_imm_sel, out_imm, out_illegal
   );

   modport master (
      output flush, in_valid, in_inst, in_pc, out_ready,
      input  in_ready, out_valid, out_inst, out_pc, out_imm_sel, out_imm, out_illegal
   );
endinterface
`default_nettype wire

// File: rtl/imm_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imm_sel_ctrl
// Description : Decode-side immediate select / expansion stage. Classifies the
//               opcode into a 3-bit immediate-type select, expands the 32-bit
//               immediate and registers the result. A primary output register
//               plus one skid entry keep back-pressure from dropping anything.
// Ports       : clk  - core clock, all state on the rising edge
//               rst  - synchronous reset, active-high
//               bus  - imm_sel_ctrl_if.slave (fetch handshake in, result out)
// Options     : IMM_SEL_JTYPE_EN - when defined, JAL (1101111) decodes to
//               select 101 with a J-type immediate; otherwise JAL is illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_sel_ctrl #(
   parameter int         XLEN        = 32,
   parameter logic [2:0] ILLEGAL_SEL = 3'b111
) (
   input  wire logic     clk,
   input  wire logic     rst,
   imm_sel_ctrl_if.slave bus
);

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [2:0]      sel;
      logic            illegal;
   } entry_t;

   entry_t pri_q,  pri_d;
   entry_t skid_q, skid_d;
   logic   pri_valid_q,  pri_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   in_ready_q,   in_ready_d;

   entry_t     new_e;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       sgn;
   logic       accept;

   assign opcode = bus.in_inst[6:0];
   assign funct3 = bus.in_inst[14:12];
   assign sgn    = bus.in_inst[XLEN-1];
   // A flush-cycle input is discarded rather than accepted.
   assign accept = bus.in_valid & in_ready_q & ~bus.flush;

   // Opcode classification and immediate expansion
   always_comb begin
      new_e         = '0;
      new_e.inst    = bus.in_inst;
      new_e.pc      = bus.in_pc;
      new_e.sel     = ILLEGAL_SEL;
      new_e.illegal = 1'b1;
      case (opcode)
         7'b0010011: begin
            new_e.illegal = 1'b0;
            // Shift-immediates carry an unsigned 5-bit shamt, not a signed imm.
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               new_e.sel = 3'b000;
               new_e.imm = {{(XLEN-5){1'b0}}, bus.in_inst[24:20]};
            end else begin
               new_e.sel = 3'b001;
               new_e.imm = {{(XLEN-12){sgn}}, bus.in_inst[31:20]};
            end
         end
         7'b0000011, 7'b1100111: begin
            new_e.illegal = 1'b0;
            new_e.sel     = 3'b001;
            new_e.imm     = {{(XLEN-12){sgn}}, bus.in_inst[31:20]};
         end
         7'b0100011: begin
            new_e.illegal = 1'b0;
            new_e.sel     = 3'b010;
            new_e.imm     = {{(XLEN-12){sgn}}, bus.in_inst[31:25], bus.in_inst[11:7]};
         end
         7'b1100011: begin
            new_e.illegal = 1'b0;
            new_e.sel     = 3'b011;
            new_e.imm     = {{(XLEN-13){sgn}}, bus.in_inst[31], bus.in_inst[7],
                             bus.in_inst[30:25], bus.in_inst[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            new_e.illegal = 1'b0;
            new_e.sel     = 3'b100;
            new_e.imm     = {bus.in_inst[31:12], 12'h000};
         end
`ifdef IMM_SEL_JTYPE_EN
         7'b1101111: begin
            new_e.illegal = 1'b0;
            new_e.sel     = 3'b101;
            new_e.imm     = {{(XLEN-21){sgn}}, bus.in_inst[31], bus.in_inst[19:12],
                             bus.in_inst[20], bus.in_inst[30:21], 1'b0};
         end
`else
         // JAL falls through to the illegal default when J-type is disabled.
`endif
         default: ;
      endcase
   end

   // Primary/skid transfer logic
   always_comb begin
      pri_d        = pri_q;
      pri_valid_d  = pri_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (bus.flush) begin
         pri_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!pri_valid_q || bus.out_ready) begin
         // Primary is free this edge: older skid entry goes first to keep
         // FIFO order. An accept cannot coincide with a full skid because
         // in_ready is low whenever the skid holds an entry.
         if (skid_valid_q) begin
            pri_d        = skid_q;
            pri_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            pri_d       = new_e;
            pri_valid_d = 1'b1;
         end else begin
            pri_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d       = new_e;
         skid_valid_d = 1'b1;
      end
      // Registered so in_ready never depends combinationally on out_ready.
      in_ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pri_q        <= '0;
         skid_q       <= '0;
         pri_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         pri_q        <= pri_d;
         skid_q       <= skid_d;
         pri_valid_q  <= pri_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = pri_valid_q;
   assign bus.out_inst    = pri_q.inst;
   assign bus.out_pc      = pri_q.pc;
   assign bus.out_imm_sel = pri_q.sel;
   assign bus.out_imm     = pri_q.imm;
   assign bus.out_illegal = pri_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_imm_sel_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_imm_sel_ctrl
// Description : Self-checking bench for imm_sel_ctrl. A behavioural model keeps
//               a depth-2 FIFO of expected results; a negedge monitor compares
//               the DUT head entry, in_ready and out_valid against it.
// Options     : IMM_SEL_JTYPE_EN - must match the DUT build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_sel_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   imm_sel_ctrl_if #(.XLEN(32)) bus ();

   imm_sel_ctrl #(
      .XLEN        (32),
      .ILLEGAL_SEL (3'b111)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [2:0]  sel;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   armed    = 1'b0;
   bit   prev_rst = 1'b0;

   // Reference decode from the ISA immediate rules, using integer arithmetic.
   function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
      exp_t       e;
      logic [6:0] op;
      logic [2:0] f3;
      int         v;
      op    = inst[6:0];
      f3    = inst[14:12];
      e.inst = inst;
      e.pc   = pc;
      e.sel  = 3'd7;
      e.imm  = 32'd0;
      e.ill  = 1'b1;
      if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
         e.sel = 3'd0; e.ill = 1'b0;
         v = int'(inst[24:20]);
         e.imm = v;
      end else if (op == 7'h13 || op == 7'h03 || op == 7'h67) begin
         e.sel = 3'd1; e.ill = 1'b0;
         v = int'(inst[31:20]);
         if (inst[31]) v = v - 4096;
         e.imm = v;
      end else if (op == 7'h23) begin
         e.sel = 3'd2; e.ill = 1'b0;
         v = int'({inst[31:25], inst[11:7]});
         if (inst[31]) v = v - 4096;
         e.imm = v;
      end else if (op == 7'h63) begin
         e.sel = 3'd3; e.ill = 1'b0;
         v = int'({inst[31], inst[7], inst[30:25], inst[11:8]});
         v = v * 2;
         if (inst[31]) v = v - 8192;
         e.imm = v;
      end else if (op == 7'h37 || op == 7'h17) begin
         e.sel = 3'd4; e.ill = 1'b0;
         e.imm = inst & 32'hFFFF_F000;
      end
`ifdef IMM_SEL_JTYPE_EN
      else if (op == 7'h6F) begin
         e.sel = 3'd5; e.ill = 1'b0;
         v = int'({inst[31], inst[19:12], inst[20], inst[30:21]});
         v = v * 2;
         if (inst[31]) v = v - (1 << 21);
         e.imm = v;
      end
`endif
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor / scoreboard: inputs settle 1ns after posedge, sampled at negedge.
   always @(negedge clk) begin
      bit   drain;
      bit   acc;
      exp_t h;
      if (armed) begin
         if (prev_rst) begin
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
            chk("rst_imm_sel",   32'(bus.out_imm_sel), 32'd0);
            chk("rst_imm",       bus.out_imm,  32'd0);
            chk("rst_inst",      bus.out_inst, 32'd0);
            chk("rst_pc",        bus.out_pc,   32'd0);
            chk("rst_illegal",   32'(bus.out_illegal), 32'd0);
         end
         chk("in_ready",  32'(bus.in_ready),  32'(sb.size() < 2));
         chk("out_valid", 32'(bus.out_valid), 32'(sb.size() > 0));
         if (sb.size() > 0) begin
            h = sb[0];
            chk("out_pc",      bus.out_pc,   h.pc);
            chk("out_inst",    bus.out_inst, h.inst);
            chk("out_imm",     bus.out_imm,  h.imm);
            chk("out_imm_sel", 32'(bus.out_imm_sel), 32'(h.sel));
            chk("out_illegal", 32'(bus.out_illegal), 32'(h.ill));
         end
      end
      drain = (sb.size() > 0) && bus.out_ready;
      acc   = bus.in_valid && (sb.size() < 2) && !bus.flush && !rst;
      if (rst || bus.flush) begin
         sb.delete();
      end else begin
         if (drain) void'(sb.pop_front());
         if (acc) sb.push_back(model(bus.in_inst, bus.in_pc));
      end
      prev_rst = rst;
      if (rst) armed = 1'b1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input logic fl);
      bus.in_valid  = v;
      bus.in_inst   = inst;
      bus.in_pc     = pc;
      bus.out_ready = ordy;
      bus.flush     = fl;
      step();
   endtask

   logic [31:0] dir_inst [0:8];
   logic [6:0]  ops      [0:10];

   initial begin
      dir_inst[0] = 32'hFFF00093;  // ADDI -1
      dir_inst[1] = 32'hFE112E23;  // SW   -4
      dir_inst[2] = 32'hFE000CE3;  // BEQ  -8
      dir_inst[3] = 32'h123450B7;  // LUI
      dir_inst[4] = 32'h01F09093;  // SLLI 31
      dir_inst[5] = 32'h4010D093;  // SRAI 1 (bit 30 must not leak)
      dir_inst[6] = 32'h0080006F;  // JAL +8
      dir_inst[7] = 32'h00000033;  // R-type, no immediate
      dir_inst[8] = 32'h80000017;  // AUIPC with sign bit
      ops[0] = 7'h13; ops[1] = 7'h03; ops[2] = 7'h67; ops[3] = 7'h23;
      ops[4] = 7'h63; ops[5] = 7'h37; ops[6] = 7'h17; ops[7] = 7'h6F;
      ops[8] = 7'h33; ops[9] = 7'h73; ops[10] = 7'h7F;

      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0;
      bus.out_ready = 1'b0; bus.flush = 1'b0;
      step(); step();
      rst = 1'b0;
      step();

      // Directed decode with a free-flowing output
      for (int i = 0; i < 9; i++) drive(1'b1, dir_inst[i], 32'h100 + 32'(i*4), 1'b1, 1'b0);
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      drive(1'b0, '0, '0, 1'b1, 1'b0);

      // Back-pressure: pc 0,4 accepted, pc 8 held until space frees up
      drive(1'b1, 32'hFFF00093, 32'h0, 1'b0, 1'b0);
      drive(1'b1, 32'hFE112E23, 32'h4, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 32'hFE000CE3, 32'h8, 1'b0, 1'b0);
      drive(1'b1, 32'hFE000CE3, 32'h8, 1'b1, 1'b0);
      drive(1'b1, 32'hFE000CE3, 32'h8, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);

      // Flush with skid full and an input presented in the flush cycle
      drive(1'b1, 32'h123450B7, 32'h20, 1'b0, 1'b0);
      drive(1'b1, 32'h01F09093, 32'h24, 1'b0, 1'b0);
      drive(1'b1, 32'hFFF00093, 32'h28, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);

      // Reset mid-stream
      drive(1'b1, 32'h123450B7, 32'h30, 1'b0, 1'b0);
      drive(1'b1, 32'h0080006F, 32'h34, 1'b0, 1'b0);
      rst = 1'b1;
      drive(1'b1, 32'hFFF00093, 32'h38, 1'b1, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         logic [31:0] r;
         r = $urandom;
         r[6:0] = ops[$urandom_range(0, 10)];
         rst = ($urandom_range(0, 199) == 0);
         drive($urandom_range(0, 3) != 0, r, $urandom & 32'hFFFF_FFFC,
               $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
      end
      rst = 1'b0;

      for (int i = 0; i < 6; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);
      @(negedge clk);
      chk("drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
